// File: rtl/rom_fetch_arbiter.sv
// Arbitrates the shared SDRAM-backed ROM read port between the 68k program ROM,
// the Z80 sound ROM and the uPD7759 sample fetcher, with aging and a watchdog.
module rom_fetch_arbiter #(
  parameter logic [23:0] M68K_BASE = 24'h000000,
  parameter logic [23:0] Z80_BASE  = 24'h040000,
  parameter logic [23:0] UPD_BASE  = 24'h050000,
  parameter int unsigned AGE_LIMIT = 8,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m68k_req,
  input  logic        m68k_bank2,
  input  logic [16:0] m68k_a,
  output logic        m68k_rdy,
  output logic [15:0] m68k_dout,
  input  logic        z80_req,
  input  logic [15:0] z80_a,
  output logic        z80_rdy,
  output logic [7:0]  z80_dout,
  input  logic        upd_req,
  input  logic [16:0] upd_a,
  output logic        upd_rdy,
  output logic [7:0]  upd_dout,
  output logic        sdr_req,
  output logic [23:0] sdr_addr,
  input  logic        sdr_ack,
  input  logic [15:0] sdr_data,
  output logic        timeout_err
);

  localparam int unsigned AW = $clog2(AGE_LIMIT + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(AGE_LIMIT);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {G_M68K, G_Z80, G_UPD} port_t;

  state_t        state;
  port_t         gnt;
  port_t         sel;
  logic          byte_sel;
  logic [WW-1:0] wd;
  logic [AW-1:0] z80_age, upd_age;
  logic          m68k_served, z80_served, upd_served;

  logic          m68k_pend, z80_pend, upd_pend, any_pend;
  logic          z80_aged, upd_aged;
  logic [23:0]   sel_addr;
  logic          sel_lsb;
  logic          finish;
  logic [15:0]   rdata;
  logic [7:0]    rbyte;
  logic          m68k_deliver, z80_deliver, upd_deliver;
  logic          z80_hold, upd_hold;

  assign m68k_pend = m68k_req & ~m68k_served;
  assign z80_pend  = z80_req  & ~z80_served;
  assign upd_pend  = upd_req  & ~upd_served;
  assign any_pend  = m68k_pend | z80_pend | upd_pend;
  assign z80_aged  = (z80_age == AGE_MAX);
  assign upd_aged  = (upd_age == AGE_MAX);

  always_comb begin
    sel      = G_UPD;
    sel_addr = UPD_BASE + {8'h00, upd_a[16:1]};
    sel_lsb  = upd_a[0];
    if (z80_pend && z80_aged) begin
      sel      = G_Z80;
      sel_addr = Z80_BASE + {9'h000, z80_a[15:1]};
      sel_lsb  = z80_a[0];
    end else if (upd_pend && upd_aged) begin
      sel = G_UPD;
    end else if (m68k_pend) begin
      sel      = G_M68K;
      sel_addr = M68K_BASE + {6'h00, m68k_bank2, m68k_a};
      sel_lsb  = 1'b0;
    end else if (z80_pend) begin
      sel      = G_Z80;
      sel_addr = Z80_BASE + {9'h000, z80_a[15:1]};
      sel_lsb  = z80_a[0];
    end
  end

  // A completion is delivered only if the requester still holds req at that edge.
  assign finish       = (state == S_WAIT) && (sdr_ack || wd == WD_LAST);
  assign rdata        = sdr_ack ? sdr_data : 16'hFFFF;
  assign rbyte        = byte_sel ? rdata[15:8] : rdata[7:0];
  assign m68k_deliver = finish && gnt == G_M68K && m68k_req;
  assign z80_deliver  = finish && gnt == G_Z80  && z80_req;
  assign upd_deliver  = finish && gnt == G_UPD  && upd_req;

  // Ages stay cleared while the port is being granted or is in service.
  assign z80_hold = (state == S_IDLE) ? (any_pend && sel == G_Z80) : (gnt == G_Z80);
  assign upd_hold = (state == S_IDLE) ? (any_pend && sel == G_UPD) : (gnt == G_UPD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      gnt         <= G_M68K;
      byte_sel    <= 1'b0;
      wd          <= '0;
      sdr_req     <= 1'b0;
      sdr_addr    <= '0;
      timeout_err <= 1'b0;
      m68k_rdy    <= 1'b0;
      z80_rdy     <= 1'b0;
      upd_rdy     <= 1'b0;
      m68k_dout   <= '0;
      z80_dout    <= '0;
      upd_dout    <= '0;
      m68k_served <= 1'b0;
      z80_served  <= 1'b0;
      upd_served  <= 1'b0;
      z80_age     <= '0;
      upd_age     <= '0;
    end else begin
      m68k_rdy    <= m68k_deliver;
      z80_rdy     <= z80_deliver;
      upd_rdy     <= upd_deliver;
      timeout_err <= 1'b0;
      if (m68k_deliver) m68k_dout <= rdata;
      if (z80_deliver)  z80_dout  <= rbyte;
      if (upd_deliver)  upd_dout  <= rbyte;

      m68k_served <= m68k_req & (m68k_served | m68k_deliver);
      z80_served  <= z80_req  & (z80_served  | z80_deliver);
      upd_served  <= upd_req  & (upd_served  | upd_deliver);

      if (!z80_pend || z80_hold)   z80_age <= '0;
      else if (!z80_aged)          z80_age <= z80_age + AW'(1);
      if (!upd_pend || upd_hold)   upd_age <= '0;
      else if (!upd_aged)          upd_age <= upd_age + AW'(1);

      case (state)
        S_IDLE: begin
          if (any_pend) begin
            gnt      <= sel;
            sdr_addr <= sel_addr;
            byte_sel <= sel_lsb;
            sdr_req  <= 1'b1;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (finish) begin
            sdr_req <= 1'b0;
            if (!sdr_ack) timeout_err <= 1'b1;
            state   <= S_DONE;
          end else begin
            wd <= wd + WW'(1);
          end
        end
        S_DONE: begin
          wd    <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed self-checking bench for rom_fetch_arbiter with a simple SDRAM responder.
module tb_rom_fetch_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m68k_req, m68k_bank2;
  logic [16:0] m68k_a;
  logic        m68k_rdy;
  logic [15:0] m68k_dout;
  logic        z80_req;
  logic [15:0] z80_a;
  logic        z80_rdy;
  logic [7:0]  z80_dout;
  logic        upd_req;
  logic [16:0] upd_a;
  logic        upd_rdy;
  logic [7:0]  upd_dout;
  logic        sdr_req;
  logic [23:0] sdr_addr;
  logic        sdr_ack;
  logic [15:0] sdr_data;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  logic        rsp_en = 1'b0;
  int          rsp_delay = 0;
  logic [15:0] rsp_data = 16'h0000;
  int          wait_cnt = 0;

  rom_fetch_arbiter #(
    .M68K_BASE(24'h000000), .Z80_BASE(24'h040000), .UPD_BASE(24'h050000),
    .AGE_LIMIT(8), .TIMEOUT(255)
  ) dut (
    .clk(clk), .reset(reset),
    .m68k_req(m68k_req), .m68k_bank2(m68k_bank2), .m68k_a(m68k_a),
    .m68k_rdy(m68k_rdy), .m68k_dout(m68k_dout),
    .z80_req(z80_req), .z80_a(z80_a), .z80_rdy(z80_rdy), .z80_dout(z80_dout),
    .upd_req(upd_req), .upd_a(upd_a), .upd_rdy(upd_rdy), .upd_dout(upd_dout),
    .sdr_req(sdr_req), .sdr_addr(sdr_addr), .sdr_ack(sdr_ack), .sdr_data(sdr_data),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Acks rsp_delay cycles after sdr_req is first seen high.
  initial begin
    sdr_ack  = 1'b0;
    sdr_data = 16'h0000;
    forever begin
      @(posedge clk); #1;
      sdr_ack = 1'b0;
      if (rsp_en && sdr_req) begin
        if (wait_cnt == rsp_delay) begin
          sdr_ack  = 1'b1;
          sdr_data = rsp_data;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, time=%0t required finish", $time);
    $fatal(1, "global timeout");
  end

  task test_reset;
    reset = 1'b1;
    m68k_req = 0; m68k_bank2 = 0; m68k_a = '0;
    z80_req = 0; z80_a = '0; upd_req = 0; upd_a = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({sdr_req, timeout_err, m68k_rdy, z80_rdy, upd_rdy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000",
               {sdr_req, timeout_err, m68k_rdy, z80_rdy, upd_rdy});
    end
    checks++;
    if (sdr_addr !== 24'h0) begin errors++; $display("FAIL reset_addr: got %h required 000000", sdr_addr); end
    checks++;
    if ({m68k_dout, z80_dout, upd_dout} !== 32'h0) begin
      errors++;
      $display("FAIL reset_dout: got %h %h %h required 0 0 0", m68k_dout, z80_dout, upd_dout);
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task test_reset_mid_wait;
    int seen;
    int bad;
    rsp_en = 0;
    m68k_bank2 = 0; m68k_a = 17'h00100; m68k_req = 1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (sdr_req) seen = 1;
    end
    checks++;
    if (seen != 1 || sdr_addr !== 24'h000100) begin
      errors++;
      $display("FAIL rmw_launch: seen=%0d addr=%h required 1 000100", seen, sdr_addr);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (sdr_req !== 1'b0) begin errors++; $display("FAIL rmw_async: sdr_req=%b required 0", sdr_req); end
    m68k_req = 0;
    @(negedge clk) reset = 1'b0;
    rsp_en = 1; rsp_delay = 0; rsp_data = 16'h1357;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m68k_rdy || sdr_req || timeout_err) bad++;
    end
    checks++;
    if (bad != 0 || m68k_dout !== 16'h0) begin
      errors++;
      $display("FAIL rmw_stale: activity=%0d dout=%h required 0 0000", bad, m68k_dout);
    end
  endtask

  task test_m68k_read;
    int k, rise_c, ack_c, rdy_c, rdy_n;
    logic [23:0] addr;
    rsp_en = 1; rsp_delay = 3; rsp_data = 16'hBEEF;
    m68k_bank2 = 1; m68k_a = 17'h00010; m68k_req = 1;
    rise_c = -1; ack_c = -1; rdy_c = -1; rdy_n = 0; addr = '0;
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (sdr_req && rise_c < 0) begin rise_c = k; addr = sdr_addr; end
      if (sdr_ack) ack_c = k;
      if (m68k_rdy) begin rdy_c = k; rdy_n++; m68k_req = 0; end
    end
    checks++;
    if (addr !== 24'h020010) begin errors++; $display("FAIL m68k_addr: got %h required 020010", addr); end
    checks++;
    if (ack_c - rise_c != 3) begin errors++; $display("FAIL m68k_ack_lat: got %0d required 3", ack_c - rise_c); end
    checks++;
    if (rdy_c - ack_c != 1 || rdy_n != 1) begin
      errors++;
      $display("FAIL m68k_rdy: lat=%0d pulses=%0d required 1 1", rdy_c - ack_c, rdy_n);
    end
    checks++;
    if (m68k_dout !== 16'hBEEF) begin errors++; $display("FAIL m68k_dout: got %h required BEEF", m68k_dout); end
  endtask

  task test_z80_read;
    logic [15:0] a_tab [2];
    logic [7:0]  d_tab [2];
    int rdy_n;
    logic [23:0] addr;
    logic prev;
    a_tab[0] = 16'h1235; d_tab[0] = 8'hA5;
    a_tab[1] = 16'h1234; d_tab[1] = 8'h5A;
    rsp_en = 1; rsp_delay = 1; rsp_data = 16'hA55A;
    for (int t = 0; t < 2; t++) begin
      z80_a = a_tab[t]; z80_req = 1;
      rdy_n = 0; addr = '0; prev = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (sdr_req && !prev) addr = sdr_addr;
        prev = sdr_req;
        if (z80_rdy) begin rdy_n++; z80_req = 0; end
      end
      checks++;
      if (addr !== 24'h04091A) begin errors++; $display("FAIL z80_addr%0d: got %h required 04091A", t, addr); end
      checks++;
      if (rdy_n != 1 || z80_dout !== d_tab[t]) begin
        errors++;
        $display("FAIL z80_data%0d: pulses=%0d dout=%h required 1 %h", t, rdy_n, z80_dout, d_tab[t]);
      end
    end
  endtask

  task test_fairness;
    logic [23:0] g [4];
    logic [23:0] exp_g [4];
    int n, z_n, u_n, m_n;
    logic prev, relow;
    exp_g[0] = 24'h000005; exp_g[1] = 24'h000005;
    exp_g[2] = 24'h040008; exp_g[3] = 24'h050010;
    for (int i = 0; i < 4; i++) g[i] = '0;
    rsp_en = 1; rsp_delay = 2; rsp_data = 16'hC311;
    m68k_bank2 = 0; m68k_a = 17'h00005; z80_a = 16'h0010; upd_a = 17'h00020;
    m68k_req = 1; z80_req = 1; upd_req = 1;
    n = 0; z_n = 0; u_n = 0; m_n = 0; prev = 0; relow = 0;
    for (int i = 0; i < 120 && n < 4; i++) begin
      @(negedge clk);
      if (relow) begin m68k_req = 1; relow = 0; end
      if (m68k_rdy) begin m68k_req = 0; relow = 1; m_n++; end
      if (z80_rdy) begin z80_req = 0; z_n++; end
      if (upd_rdy) begin upd_req = 0; u_n++; end
      if (sdr_req && !prev) begin g[n] = sdr_addr; n++; end
      prev = sdr_req;
    end
    m68k_req = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (m68k_rdy) m_n++;
      if (z80_rdy) begin z80_req = 0; z_n++; end
      if (upd_rdy) begin upd_req = 0; u_n++; end
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL fair_count: got %0d grants required 4", n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (g[i] !== exp_g[i]) begin
        errors++;
        $display("FAIL fair_grant%0d: got %h required %h", i, g[i], exp_g[i]);
      end
    end
    checks++;
    if (m_n != 2 || z_n != 1 || u_n != 1) begin
      errors++;
      $display("FAIL fair_rdy: m68k=%0d z80=%0d upd=%0d required 2 1 1", m_n, z_n, u_n);
    end
    checks++;
    if (z80_dout !== 8'h11 || upd_dout !== 8'h11 || m68k_dout !== 16'hC311) begin
      errors++;
      $display("FAIL fair_dout: got %h %h %h required C311 11 11", m68k_dout, z80_dout, upd_dout);
    end
  endtask

  task test_timeout;
    int req_n, te_n, rdy_n, after;
    logic [23:0] addr;
    rsp_en = 0;
    upd_a = 17'h00003; upd_req = 1;
    req_n = 0; te_n = 0; rdy_n = 0; after = 0; addr = '0;
    for (int i = 0; i < 400 && after < 3; i++) begin
      @(negedge clk);
      if (sdr_req) begin req_n++; addr = sdr_addr; end
      if (timeout_err) te_n++;
      if (upd_rdy) begin rdy_n++; upd_req = 0; end
      if (rdy_n > 0) after++;
    end
    checks++;
    if (addr !== 24'h050001) begin errors++; $display("FAIL to_addr: got %h required 050001", addr); end
    checks++;
    if (req_n != 255) begin errors++; $display("FAIL to_wait_len: got %0d required 255", req_n); end
    checks++;
    if (te_n != 1 || rdy_n != 1) begin
      errors++;
      $display("FAIL to_pulses: timeout_err=%0d upd_rdy=%0d required 1 1", te_n, rdy_n);
    end
    checks++;
    if (upd_dout !== 8'hFF) begin errors++; $display("FAIL to_dout: got %h required FF", upd_dout); end
  endtask

  task test_drop_during_wait;
    int rdy_n, launched;
    logic [23:0] addr;
    logic prev;
    rsp_en = 1; rsp_delay = 3; rsp_data = 16'h1234;
    z80_a = 16'h0001; z80_req = 1;
    rdy_n = 0; launched = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sdr_req && !launched) begin launched = 1; z80_req = 0; end
      if (z80_rdy) rdy_n++;
    end
    checks++;
    if (launched != 1 || rdy_n != 0 || z80_dout !== 8'h11) begin
      errors++;
      $display("FAIL drop_suppress: launched=%0d rdy=%0d dout=%h required 1 0 11", launched, rdy_n, z80_dout);
    end
    rsp_delay = 0; rsp_data = 16'h7788;
    z80_a = 16'h0003; z80_req = 1;
    rdy_n = 0; addr = '0; prev = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (sdr_req && !prev) addr = sdr_addr;
      prev = sdr_req;
      if (z80_rdy) begin rdy_n++; z80_req = 0; end
    end
    checks++;
    if (addr !== 24'h040001) begin errors++; $display("FAIL drop_readdr: got %h required 040001", addr); end
    checks++;
    if (rdy_n != 1 || z80_dout !== 8'h77) begin
      errors++;
      $display("FAIL drop_reserve: rdy=%0d dout=%h required 1 77", rdy_n, z80_dout);
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid_wait;
    test_m68k_read;
    test_z80_read;
    test_fairness;
    test_timeout;
    test_drop_during_wait;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_fetch_arbiter.md
Name: rom_fetch_arbiter

Overview:
- Shares the single external program/sample ROM read port (SDRAM-backed) between three requesters: the 68000 program ROM (base range and extra code bank), the Z80 sound ROM, and the uPD7759 sample fetch.
- Sits between the chip-select decode outputs and the SDRAM controller.
- Maps each requester address into one flat word-address space.
- Applies fixed priority with anti-starvation aging, and returns data with a one-cycle ready pulse per requester.

Parameters:
- M68K_BASE, 24'h000000, word base of the 68k region. Base ROM occupies words 0x00000-0x1FFFF; the extra bank follows at words 0x20000-0x3FFFF.
- Z80_BASE, 24'h040000, word base of the Z80 ROM region.
- UPD_BASE, 24'h050000, word base of the sample ROM region.
- AGE_LIMIT, 8, number of waiting cycles after which a lower-priority requester is promoted above the 68k.
- TIMEOUT, 255, number of cycles without sdr_ack before the transaction is abandoned.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m68k_req  in  1  level request (68k ROM cs decoded with AS asserted)
- m68k_bank2  in  1  1 = extra code bank (0x300000-0x33FFFF)
- m68k_a  in  17  68k word address bits [17:1]
- m68k_rdy  out  1  one-cycle pulse: m68k_dout is valid
- m68k_dout  out  16  read word, held until the next 68k completion
- z80_req  in  1  level request (Z80 ROM cs)
- z80_a  in  16  Z80 byte address
- z80_rdy  out  1  one-cycle pulse
- z80_dout  out  8  byte selected by z80_a[0]: 0 = low byte [7:0], 1 = high byte [15:8]
- upd_req  in  1  level request from the sample fetcher
- upd_a  in  17  sample byte address
- upd_rdy  out  1  one-cycle pulse
- upd_dout  out  8  byte selected by upd_a[0], same rule as z80_dout
- sdr_req  out  1  held high until sdr_ack
- sdr_addr  out  24  word address, stable while sdr_req is high
- sdr_ack  in  1  one-cycle pulse: sdr_data is valid
- sdr_data  in  16  read data
- timeout_err  out  1  one-cycle pulse when a transaction times out

Behaviour:
- Reset (asynchronous, any state):
  - state returns to IDLE.
  - All rdy outputs, sdr_req and timeout_err are 0.
  - All dout registers, sdr_addr, age counters, watchdog and served flags are 0.
- Served flag, one per port:
  - Set when that port's rdy pulses.
  - Cleared in any cycle its req is 0.
  - A port is pending when req=1 and served=0. A new request therefore needs at least one cycle of req low.
- Address mapping, computed at grant and registered into sdr_addr:
  - 68k: M68K_BASE + {m68k_bank2, m68k_a}.
  - Z80: Z80_BASE + z80_a[15:1].
  - uPD: UPD_BASE + upd_a[16:1].
  - The low address bit is latched with the grant for byte select.
  - Additions are 24-bit, and overflow wraps.
- Age counters (Z80 and uPD only):
  - Increment each cycle the port is pending and not granted; saturate at AGE_LIMIT.
  - Clear on grant or when the port is not pending.
  - A port is aged when its counter equals AGE_LIMIT.
- Grant priority, evaluated in IDLE:
  1. aged Z80
  2. aged uPD
  3. 68k
  4. Z80
  5. uPD
- FSM: IDLE -> WAIT -> DONE -> IDLE.
  - IDLE: if any port is pending, latch the granted port id and mapped address, set sdr_req=1 the next cycle, and go to WAIT. Otherwise stay.
  - WAIT: sdr_req=1 and the watchdog increments.
    - On sdr_ack: capture sdr_data, drop sdr_req in the same edge, go to DONE.
    - If the watchdog reaches TIMEOUT first: drop sdr_req, capture 16'hFFFF, pulse timeout_err, go to DONE.
  - DONE: pulse rdy for the granted port and update its dout; byte ports take the selected byte. Clear the watchdog. Go to IDLE.
- Latency:
  - The pending request is seen in IDLE at cycle 0; sdr_req rises at cycle 1.
  - If sdr_ack arrives at cycle N, rdy pulses at cycle N+1.
  - With zero-wait ack (N=1), rdy pulses at cycle 2 and the next grant can occur at cycle 3.
- Requester drops req during WAIT: the transaction completes normally. rdy and the dout update are suppressed, and the served flag is not set.
- sdr_ack outside WAIT: ignored.
- Simultaneous requests: only one grant per IDLE cycle. The others stay pending and age.
- Fairness bound: an aged port is served within one transaction of aging.

Test Plan:
- Reset mid-WAIT (68k read in flight, assert reset) -> sdr_req=0 immediately; m68k_rdy stays 0 after release; no stale completion.
- Single 68k read, m68k_bank2=1, m68k_a=17'h00010, ack 3 cycles after sdr_req -> sdr_addr=24'h020010; m68k_rdy pulses 1 cycle after ack; m68k_dout=sdr_data (e.g. 16'hBEEF).
- Z80 read z80_a=16'h1235, sdr_data=16'hA55A -> sdr_addr=24'h04091A; z80_dout=8'hA5. Repeat with z80_a=16'h1234 -> z80_dout=8'h5A.
- All three requesters asserted together, 68k re-requesting continuously, AGE_LIMIT=8 -> 68k granted first; Z80 granted no later than the first IDLE after its age counter reaches 8; uPD granted after that; no port starved.
- sdr_ack never arrives, TIMEOUT=255 -> sdr_req drops after 255 WAIT cycles; timeout_err pulses once; upd_dout=8'hFF; upd_rdy pulses.
- Z80 drops req during WAIT -> no z80_rdy; z80_dout unchanged; a new z80 request after one low cycle is served normally.
